// File: rtl/scan_peak_finder_pkg.sv
// Shared definitions for the scan peak finder.
// Holds the finder state encoding and the default sweep-counter width.
package scan_peak_finder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } spf_state_e;

  localparam int unsigned SPF_CW_DEFAULT = 16;

endpackage

// File: rtl/scan_peak_finder_peak_track.sv
// peak_track: signed extreme tracker with position capture.
//   clk, rst  : clock, synchronous active-high reset (clears val/pos_out)
//   load      : take sig/pos unconditionally (start of a sweep)
//   update    : take sig/pos only if sig strictly beats val
//   mode      : 1 = track maximum, 0 = track minimum
//   sig, pos  : candidate sample and its ramp position (signed, R bits)
//   val       : tracked extreme value
//   pos_out   : ramp position of the tracked extreme
module peak_track #(
  parameter int unsigned R = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         update,
  input  logic         mode,
  input  logic [R-1:0] sig,
  input  logic [R-1:0] pos,
  output logic [R-1:0] val,
  output logic [R-1:0] pos_out
);

  logic [R-1:0] val_q, val_d;
  logic [R-1:0] pos_q, pos_d;
  logic         better;

  // Strict compare: a tie never displaces the earlier position.
  always_comb begin
    better = mode ? ($signed(sig) > $signed(val_q))
                  : ($signed(sig) < $signed(val_q));
    val_d  = val_q;
    pos_d  = pos_q;
    if (load || (update && better)) begin
      val_d = sig;
      pos_d = pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      pos_q <= '0;
    end else begin
      val_q <= val_d;
      pos_q <= pos_d;
    end
  end

  assign val     = val_q;
  assign pos_out = pos_q;

endmodule

// File: rtl/scan_peak_finder.sv
// scan_peak_finder: finds the extreme of sig_in over one ramp sweep
// (trig_low .. trig_hig) and reports the ramp position where it occurred.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : run the finder; 0 forces IDLE
//   clear               : zero results and sweep counter, go to IDLE
//   mode                : 1 = maximum, 0 = minimum
//   timeout             : max SWEEP length in cycles, 0 = no timeout
//   ramp_in, sig_in     : signed ramp position and measured signal
//   trig_low, trig_hig  : ramp at low / high limit pulses
//   peak_val, peak_pos  : result of the last completed sweep
//   valid               : one-cycle pulse when results update
//   to_flag             : one-cycle pulse when a sweep times out
//   busy                : high while in SWEEP
//   sweep_cnt           : completed sweeps, saturating
module scan_peak_finder
  import scan_peak_finder_pkg::*;
#(
  parameter int unsigned R  = 14,
  parameter int unsigned CW = SPF_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic          mode,
  input  logic [31:0]   timeout,
  input  logic [R-1:0]  ramp_in,
  input  logic          trig_low,
  input  logic          trig_hig,
  input  logic [R-1:0]  sig_in,
  output logic [R-1:0]  peak_val,
  output logic [R-1:0]  peak_pos,
  output logic          valid,
  output logic          to_flag,
  output logic          busy,
  output logic [CW-1:0] sweep_cnt
);

  spf_state_e    state_q, state_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [R-1:0]  peak_val_q, peak_val_d;
  logic [R-1:0]  peak_pos_q, peak_pos_d;
  logic [CW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          valid_q, valid_d;
  logic          to_flag_q, to_flag_d;
  logic          busy_q, busy_d;
  logic          trk_load, trk_update;
  logic [R-1:0]  trk_val, trk_pos;

  peak_track #(.R(R)) u_track (
    .clk     (clk),
    .rst     (rst),
    .load    (trk_load),
    .update  (trk_update),
    .mode    (mode),
    .sig     (sig_in),
    .pos     (ramp_in),
    .val     (trk_val),
    .pos_out (trk_pos)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    peak_val_d  = peak_val_q;
    peak_pos_d  = peak_pos_q;
    sweep_cnt_d = sweep_cnt_q;
    valid_d     = 1'b0;
    to_flag_d   = 1'b0;
    trk_load    = 1'b0;
    trk_update  = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      cyc_d       = '0;
      peak_val_d  = '0;
      peak_pos_d  = '0;
      sweep_cnt_d = '0;
    end else if (!enable) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (trig_low && !trig_hig) begin
            state_d  = ST_SWEEP;
            trk_load = 1'b1;
            cyc_d    = 32'd1;
          end
        end
        ST_SWEEP: begin
          // trig_hig beats both restart and timeout in the same cycle.
          if (trig_hig) begin
            trk_update = 1'b1;
            state_d    = ST_DONE;
          end else if (trig_low) begin
            trk_load = 1'b1;
            cyc_d    = 32'd1;
          end else if ((timeout != '0) && (cyc_q == timeout)) begin
            to_flag_d = 1'b1;
            state_d   = ST_ARM;
          end else begin
            trk_update = 1'b1;
            cyc_d      = cyc_q + 32'd1;
          end
        end
        ST_DONE: begin
          peak_val_d = trk_val;
          peak_pos_d = trk_pos;
          valid_d    = 1'b1;
          if (sweep_cnt_q != '1) sweep_cnt_d = sweep_cnt_q + CW'(1);
          state_d = ST_ARM;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_SWEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      peak_val_q  <= '0;
      peak_pos_q  <= '0;
      sweep_cnt_q <= '0;
      valid_q     <= 1'b0;
      to_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      peak_val_q  <= peak_val_d;
      peak_pos_q  <= peak_pos_d;
      sweep_cnt_q <= sweep_cnt_d;
      valid_q     <= valid_d;
      to_flag_q   <= to_flag_d;
      busy_q      <= busy_d;
    end
  end

  assign peak_val  = peak_val_q;
  assign peak_pos  = peak_pos_q;
  assign valid     = valid_q;
  assign to_flag   = to_flag_q;
  assign busy      = busy_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_scan_peak_finder.sv
// Self-checking bench for scan_peak_finder: directed scenarios plus
// randomized sweeps checked against a sweep-level reference model.
module tb_scan_peak_finder;

  localparam int     R       = 14;
  localparam int     CW      = 4;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, enable, clear, mode;
  logic [31:0]   timeout;
  logic [R-1:0]  ramp_in, sig_in;
  logic          trig_low, trig_hig;
  logic [R-1:0]  peak_val, peak_pos;
  logic          valid, to_flag, busy;
  logic [CW-1:0] sweep_cnt;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint exp_val = 0, exp_pos = 0, exp_cnt = 0;

  scan_peak_finder #(.R(R), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .mode      (mode),
    .timeout   (timeout),
    .ramp_in   (ramp_in),
    .trig_low  (trig_low),
    .trig_hig  (trig_hig),
    .sig_in    (sig_in),
    .peak_val  (peak_val),
    .peak_pos  (peak_pos),
    .valid     (valid),
    .to_flag   (to_flag),
    .busy      (busy),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tl, input logic th, input int r, input int s);
    trig_low = tl;
    trig_hig = th;
    ramp_in  = R'(r);
    sig_in   = R'(s);
    tick();
  endtask

  task automatic check_results(input string tag);
    check({tag, "_val"}, $signed(peak_val), exp_val);
    check({tag, "_pos"}, $signed(peak_pos), exp_pos);
    check({tag, "_cnt"}, sweep_cnt, exp_cnt);
  endtask

  // Called right after the trig_hig cycle: DONE now, valid one cycle later.
  task automatic expect_done(input string tag, input longint v, input longint p);
    check({tag, "_valid_in_done"}, valid, 0);
    check({tag, "_busy_in_done"}, busy, 0);
    exp_val = v;
    exp_pos = p;
    exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
    trig_low = 1'b0;
    trig_hig = 1'b0;
    tick();
    check({tag, "_valid"}, valid, 1);
    check_results(tag);
    tick();
    check({tag, "_valid_end"}, valid, 0);
  endtask

  // Whole sweep: trig_low on the first sample, trig_hig on the last.
  task automatic run_sweep(input string tag, input int rq[$], input int sq[$],
                           input logic m);
    int n;
    int best, bpos;
    n    = rq.size();
    mode = m;
    for (int i = 0; i < n; i++) begin
      drive(i == 0, i == n - 1, rq[i], sq[i]);
      if (i == 0) check({tag, "_busy_start"}, busy, 1);
    end
    best = sq[0];
    bpos = rq[0];
    for (int i = 1; i < n; i++)
      if (m ? (sq[i] > best) : (sq[i] < best)) begin
        best = sq[i];
        bpos = rq[i];
      end
    expect_done(tag, best, bpos);
  endtask

  initial begin
    int rq[$], sq[$];
    int first_at, n_pulse, n_valid, n, start, step;
    logic m;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; mode = 1'b1; timeout = '0;
    trig_low = 1'b0; trig_hig = 1'b0; ramp_in = '0; sig_in = '0;
    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_to_flag", to_flag, 0);
    check("rst_busy", busy, 0);
    check_results("rst");
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Peak of -|r-400| over ramp 0..1000.
    rq.delete(); sq.delete();
    for (int r = 0; r <= 1000; r++) begin
      rq.push_back(r);
      sq.push_back((r > 400) ? -(r - 400) : -(400 - r));
    end
    run_sweep("tri", rq, sq, 1'b1);
    check("tri_fixed_val", $signed(peak_val), 0);
    check("tri_fixed_pos", $signed(peak_pos), 400);
    check("tri_fixed_cnt", sweep_cnt, 1);

    // Constant signal, minimum mode: first position kept.
    rq.delete(); sq.delete();
    for (int i = 0; i < 60; i++) begin
      rq.push_back(-300 + 3 * i);
      sq.push_back(50);
    end
    run_sweep("flat", rq, sq, 1'b0);
    check("flat_fixed_pos", $signed(peak_pos), -300);

    // Restart discards an earlier larger peak; tie keeps earlier position.
    mode = 1'b1;
    drive(1, 0, -100, 10);
    drive(0, 0, -90, 900);
    drive(0, 0, -80, 20);
    drive(1, 0, -70, 30);
    drive(0, 0, -60, 40);
    drive(0, 0, -50, 35);
    drive(0, 0, -40, 40);
    drive(0, 1, -30, 5);
    expect_done("restart", 40, -60);

    // Mode switch mid-sweep applies from the next compare on.
    mode = 1'b1;
    drive(1, 0, 1, 10);
    drive(0, 0, 2, 50);
    mode = 1'b0;
    drive(0, 0, 3, 20);
    drive(0, 0, 4, 30);
    drive(0, 1, 5, 40);
    expect_done("modesw", 20, 3);

    // Randomized sweeps, some with narrow signal range to force ties.
    for (int k = 0; k < 20; k++) begin
      rq.delete(); sq.delete();
      n     = $urandom_range(2, 40);
      start = int'($urandom_range(0, 2000)) - 1000;
      step  = $urandom_range(1, 5);
      m     = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        rq.push_back(start + step * i);
        if (k % 3 == 0) sq.push_back(int'($urandom_range(0, 6)) - 3);
        else            sq.push_back(int'($urandom_range(0, 16383)) - 8192);
      end
      run_sweep($sformatf("rnd%0d", k), rq, sq, m);
    end

    // Timeout: abort at SWEEP cycle 100, results untouched.
    timeout = 32'd100;
    drive(1, 0, 0, 0);
    first_at = -1; n_pulse = 0; n_valid = 0;
    for (int k = 1; k <= 200; k++) begin
      drive(0, 0, k, 1000 + k);
      if (to_flag) begin
        n_pulse++;
        if (first_at < 0) first_at = k;
      end
      if (valid) n_valid++;
      if (k == 99) check("to_busy_99", busy, 1);
      if (k == 100) check("to_busy_100", busy, 0);
    end
    check("to_at", first_at, 100);
    check("to_pulses", n_pulse, 1);
    check("to_valid", n_valid, 0);
    check_results("to_hold");

    // trig_hig on the timeout cycle completes normally.
    rq.delete(); sq.delete();
    for (int i = 0; i <= 100; i++) begin
      rq.push_back(i);
      sq.push_back((i == 100) ? 3000 : i);
    end
    run_sweep("to_tie", rq, sq, 1'b1);
    check("to_tie_flag", to_flag, 0);
    timeout = '0;

    // enable low for one cycle mid-sweep: sweep lost, no valid.
    drive(1, 0, 0, 100);
    drive(0, 0, 1, 200);
    enable = 1'b0;
    drive(0, 0, 2, 300);
    check("en_busy", busy, 0);
    enable = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, (k == 2), 3 + k, 400);
      if (valid) n_valid++;
    end
    tick();
    if (valid) n_valid++;
    check("en_valid", n_valid, 0);
    check_results("en_hold");

    // Degenerate limits in ARM: no sweep starts.
    drive(1, 1, 5, 5);
    check("degen_busy", busy, 0);
    drive(0, 0, 6, 6);
    check("degen_busy2", busy, 0);

    // Clear after several sweeps.
    clear = 1'b1;
    drive(0, 0, 0, 0);
    clear = 1'b0;
    exp_val = 0; exp_pos = 0; exp_cnt = 0;
    check("clr_valid", valid, 0);
    check_results("clr");
    tick();
    rq = '{-5, -4, -3};
    sq = '{7, 9, 8};
    run_sweep("post_clr", rq, sq, 1'b1);

    // Reset mid-sweep.
    drive(1, 0, 10, 10);
    drive(0, 0, 11, 20);
    rst = 1'b1;
    drive(0, 0, 12, 30);
    rst = 1'b0;
    exp_val = 0; exp_pos = 0; exp_cnt = 0;
    check("rstmid_valid", valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_to", to_flag, 0);
    check_results("rstmid");
    tick();
    rq = '{20, 21, 22, 23};
    sq = '{-7, -9, -9, -1};
    run_sweep("post_rst", rq, sq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_peak_finder.md
SCAN_PEAK_FINDER -- requirements
Module: scan_peak_finder

Interface
REQ-001 SHALL have parameter R, default 14, giving the width of the signed ramp and signal samples.
REQ-002 SHALL have parameter CW, default 16, giving the width of the sweep counter.
REQ-003 SHALL have the following ports, in this order:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high, on clock clk
- enable  input  1  run the finder; 0 forces IDLE
- clear  input  1  synchronous clear of results and counter
- mode  input  1  1 = track maximum, 0 = track minimum
- timeout  input  32  maximum SWEEP length in cycles; 0 disables the timeout
- ramp_in  input  R  signed ramp value (ramp generator outA)
- trig_low  input  1  ramp-at-low-limit pulse
- trig_hig  input  1  ramp-at-high-limit pulse
- sig_in  input  R  signed measured signal, sampled in the same cycle as ramp_in
- peak_val  output  R  signed extreme value of sig_in in the last completed sweep
- peak_pos  output  R  signed ramp_in value at that extreme
- valid  output  1  one-cycle pulse when peak_val/peak_pos update
- to_flag  output  1  one-cycle pulse when a sweep is aborted by timeout
- busy  output  1  high while in SWEEP
- sweep_cnt  output  CW  number of completed sweeps, saturating

Function
REQ-004 SHALL implement states IDLE, ARM, SWEEP and DONE.
REQ-005 SHALL move IDLE->ARM when enable=1 and clear=0.
REQ-006 SHALL move ARM->SWEEP on trig_low=1 with trig_hig=0; trig_low and trig_hig high together (degenerate limits) SHALL keep ARM.
REQ-007 On entering SWEEP, SHALL load the tracker with the sig_in and ramp_in sampled in the trig_low cycle and reset the cycle counter to 1.
REQ-008 In SWEEP, each cycle SHALL replace the tracked value and position when sig_in > tracked (mode=1) or sig_in < tracked (mode=0), using signed compare.
REQ-009 Ties SHALL keep the earlier position.
REQ-010 In SWEEP, trig_hig=1 SHALL include that cycle's sample in the tracker and move to DONE.
REQ-011 In SWEEP, trig_low=1 with trig_hig=0 SHALL restart the sweep as in REQ-007 (ramp reversal or relock).
REQ-012 In DONE (exactly one cycle), peak_val and peak_pos SHALL be registered from the tracker, and they SHALL be visible with valid=1 in the cycle after DONE.
REQ-013 The cycle after DONE, sweep_cnt SHALL have incremented, saturating at 2^CW-1.
REQ-014 DONE SHALL always move to ARM.
REQ-015 Latency from the trig_hig sample to valid SHALL be 2 cycles.
REQ-016 When timeout!=0 and the SWEEP cycle counter reaches timeout without trig_hig, SHALL pulse to_flag for one cycle, go to ARM, and leave outputs and sweep_cnt unchanged.
REQ-017 trig_hig in the same cycle the counter reaches timeout SHALL win, completing a normal sweep.
REQ-018 enable=0 in any state SHALL go to IDLE next cycle and discard the partial sweep, with no valid pulse.
REQ-019 clear=1 SHALL zero peak_val, peak_pos and sweep_cnt, suppress valid and to_flag, and go to IDLE; clear has priority over all events except rst.
REQ-020 A change of mode during SWEEP SHALL take effect on the next compare only, with no restart.
REQ-021 busy SHALL equal (state==SWEEP).
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 rst SHALL set the state to IDLE, peak_val=0, peak_pos=0, valid=0, to_flag=0, busy=0, sweep_cnt=0, tracker=0 and cycle counter=0.
REQ-024 rst mid-sweep SHALL discard the sweep, with no valid pulse.

Structure
REQ-025 State encoding and the default CW SHALL live in the shared lock package.
REQ-026 The compare/hold logic SHALL be one sub-module, peak_track, with inputs load, update, mode, sig and pos and outputs val and pos_out; the FSM, timeout counter and output registers SHALL stay in scan_peak_finder.

Verification
REQ-027 mode=1, ramp 0..1000 with trig_low at 0 and trig_hig at 1000, sig_in = -|ramp_in-400| -> valid 2 cycles after trig_hig, peak_val=0, peak_pos=400, sweep_cnt=1.
REQ-028 mode=0, sig_in constant 50 -> peak_val=50, peak_pos=ramp value at trig_low (tie rule).
REQ-029 timeout=100, trig_low with no trig_hig for 200 cycles -> to_flag pulse at cycle 100 of SWEEP, no valid, outputs unchanged, state returns to ARM.
REQ-030 trig_low again mid-sweep after an earlier larger peak -> the earlier peak is discarded and only samples after the restart count.
REQ-031 enable=0 for 1 cycle mid-sweep, and separately clear=1 after 3 sweeps -> no valid for the aborted sweep; after clear, sweep_cnt=0 and peak_val=0.
REQ-032 trig_low and trig_hig asserted together in ARM -> stays in ARM; rst mid-sweep -> all outputs 0 next cycle.
